ps2_kbd_rx: RTL and testbench

Parametrised PS/2 keyboard receiver, the successor to the raw kbd clock/data pass-through used for signal tapping.
- Synchronises the keyboard clock and data lines, deframes 11-bit PS/2 frames, checks parity and stop bit, and recovers from stalled frames by timeout.
- Optionally folds E0/F0 prefixes into flags.
- Buffers decoded codes in a FIFO read through a valid/ready handshake.
- Sits between the board keyboard pins and the big_core keyboard MMIO register.

---
 rtl/ps2_kbd_rx.sv | 205 ++++++++++++++++++++
 tb/tb_ps2_kbd_rx.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: synchronises the pins, deframes 11-bit frames,
// folds E0/F0 prefixes into flags and queues codes in a valid/ready FIFO.
module ps2_kbd_rx #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter bit          DECODE_PREFIX  = 1'b1
) (
  input  logic                        Clk,
  input  logic                        Rst_n,
  input  logic                        KbdClk,
  input  logic                        KbdData,
  input  logic                        RdReady,
  output logic                        RdValid,
  output logic [7:0]                  RdCode,
  output logic                        RdExt,
  output logic                        RdBreak,
  output logic [$clog2(FIFO_DEPTH):0] Count,
  output logic                        Busy,
  output logic                        ParityErr,
  output logic                        FrameErr,
  output logic                        Overflow,
  input  logic                        ClrErr
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned ENT_W = 10;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [SYNC_STAGES-1:0] clkSync;
  logic [SYNC_STAGES-1:0] dataSync;
  logic                   clkPrev;
  logic                   syncClk;
  logic                   syncData;
  logic                   fallEdge;

  state_t                 state;
  logic [7:0]             shiftReg;
  logic [2:0]             bitCnt;
  logic                   parBit;
  logic [TO_W-1:0]        toCnt;
  logic                   extPend;
  logic                   brkPend;
  logic                   pushValid;
  logic [ENT_W-1:0]       pushEntry;

  logic [ENT_W-1:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       rdPtr;
  logic [PTR_W-1:0]       wrPtr;
  logic [PTR_W-1:0]       rdPtrInc;
  logic                   pop;
  logic                   full;
  logic                   doPush;
  logic                   drop;
  logic [CNT_W-1:0]       countNext;
  logic [ENT_W-1:0]       headNext;

  assign syncClk  = clkSync[SYNC_STAGES-1];
  assign syncData = dataSync[SYNC_STAGES-1];
  assign fallEdge = clkPrev & ~syncClk;

  // Input synchronisers, preset to the idle-high bus level
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      clkSync  <= '1;
      dataSync <= '1;
      clkPrev  <= 1'b1;
    end else begin
      clkSync  <= {clkSync[SYNC_STAGES-2:0], KbdClk};
      dataSync <= {dataSync[SYNC_STAGES-2:0], KbdData};
      clkPrev  <= syncClk;
    end
  end

  // Frame FSM; the timeout only runs while a frame is open and no edge arrives
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state     <= IDLE;
      shiftReg  <= '0;
      bitCnt    <= '0;
      parBit    <= 1'b0;
      toCnt     <= '0;
      extPend   <= 1'b0;
      brkPend   <= 1'b0;
      pushValid <= 1'b0;
      pushEntry <= '0;
      Busy      <= 1'b0;
      ParityErr <= 1'b0;
      FrameErr  <= 1'b0;
    end else begin
      ParityErr <= 1'b0;
      FrameErr  <= 1'b0;
      pushValid <= 1'b0;
      if (fallEdge) begin
        toCnt <= '0;
        case (state)
          IDLE: begin
            if (!syncData) begin
              state  <= DATA;
              bitCnt <= '0;
              Busy   <= 1'b1;
            end
          end
          DATA: begin
            shiftReg <= {syncData, shiftReg[7:1]};
            bitCnt   <= bitCnt + 3'd1;
            if (bitCnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            parBit <= syncData;
            state  <= STOP;
          end
          STOP: begin
            state <= IDLE;
            Busy  <= 1'b0;
            if (!syncData) begin
              FrameErr <= 1'b1;
              extPend  <= 1'b0;
              brkPend  <= 1'b0;
            end else if (!(^{shiftReg, parBit})) begin
              ParityErr <= 1'b1;
              extPend   <= 1'b0;
              brkPend   <= 1'b0;
            end else if (DECODE_PREFIX && shiftReg == 8'hE0) begin
              extPend <= 1'b1;
            end else if (DECODE_PREFIX && shiftReg == 8'hF0) begin
              brkPend <= 1'b1;
            end else begin
              pushValid <= 1'b1;
              pushEntry <= DECODE_PREFIX ? {extPend, brkPend, shiftReg} : {2'b00, shiftReg};
              extPend   <= 1'b0;
              brkPend   <= 1'b0;
            end
          end
          default: begin
            state <= IDLE;
            Busy  <= 1'b0;
          end
        endcase
      end else if (state == IDLE) begin
        toCnt <= '0;
      end else if (toCnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
        state    <= IDLE;
        Busy     <= 1'b0;
        FrameErr <= 1'b1;
        extPend  <= 1'b0;
        brkPend  <= 1'b0;
        toCnt    <= '0;
      end else begin
        toCnt <= toCnt + TO_W'(1);
      end
    end
  end

  assign pop      = RdValid && RdReady;
  assign full     = (Count == CNT_W'(FIFO_DEPTH));
  assign doPush   = pushValid && (!full || pop);
  assign drop     = pushValid && full && !pop;
  assign rdPtrInc = rdPtr + PTR_W'(1);

  // Next occupancy and next head; a push into an emptying FIFO bypasses memory
  always_comb begin
    countNext = Count;
    headNext  = {RdExt, RdBreak, RdCode};
    case ({doPush, pop})
      2'b10:   countNext = Count + CNT_W'(1);
      2'b01:   countNext = Count - CNT_W'(1);
      default: countNext = Count;
    endcase
    if (pop) begin
      headNext = (Count == CNT_W'(1)) ? pushEntry : mem[rdPtrInc];
    end else if (Count == '0 && doPush) begin
      headNext = pushEntry;
    end
  end

  always_ff @(posedge Clk) begin
    if (doPush) mem[wrPtr] <= pushEntry;
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      rdPtr    <= '0;
      wrPtr    <= '0;
      Count    <= '0;
      RdValid  <= 1'b0;
      RdCode   <= '0;
      RdExt    <= 1'b0;
      RdBreak  <= 1'b0;
      Overflow <= 1'b0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PTR_W'(1);
      if (pop) rdPtr <= rdPtrInc;
      Count   <= countNext;
      RdValid <= (countNext != '0);
      {RdExt, RdBreak, RdCode} <= headNext;
      if (drop) Overflow <= 1'b1;
      else if (ClrErr) Overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Directed bench for ps2_kbd_rx: prefix-decoding and raw instances share the pins,
// each checked against its own expected-code queue.
module tb_ps2_kbd_rx;

  localparam int SYNC  = 2;
  localparam int DEPTH = 8;
  localparam int TO    = 300;
  localparam int H     = 6;

  logic clk = 1'b0;
  logic rst_n, kc, kd, rdyA, clrErr;
  logic rdyB = 1'b1;

  logic       vA, extA, brkA, busyA, perA, ferA, ovA;
  logic [7:0] codeA;
  logic [3:0] cntA;
  logic       vB, extB, brkB, busyB, perB, ferB, ovB;
  logic [7:0] codeB;
  logic [3:0] cntB;

  logic [9:0] qA[$];
  logic [9:0] qB[$];
  int  nCmp = 0;
  int  nErr = 0;
  int  nPar = 0;
  int  nFer = 0;
  bit  mExt = 1'b0;
  bit  mBrk = 1'b0;
  int  p0, f0;

  always #5 clk = ~clk;

  ps2_kbd_rx #(.SYNC_STAGES(SYNC), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO), .DECODE_PREFIX(1'b1)) dutA (
    .Clk(clk), .Rst_n(rst_n), .KbdClk(kc), .KbdData(kd), .RdReady(rdyA),
    .RdValid(vA), .RdCode(codeA), .RdExt(extA), .RdBreak(brkA), .Count(cntA),
    .Busy(busyA), .ParityErr(perA), .FrameErr(ferA), .Overflow(ovA), .ClrErr(clrErr));

  ps2_kbd_rx #(.SYNC_STAGES(SYNC), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO), .DECODE_PREFIX(1'b0)) dutB (
    .Clk(clk), .Rst_n(rst_n), .KbdClk(kc), .KbdData(kd), .RdReady(rdyB),
    .RdValid(vB), .RdCode(codeB), .RdExt(extB), .RdBreak(brkB), .Count(cntB),
    .Busy(busyB), .ParityErr(perB), .FrameErr(ferB), .Overflow(ovB), .ClrErr(clrErr));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nCmp++;
    assert (obs === expv) else begin
      nErr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Scoreboard: every accepted head entry must match the oldest expected code
  always @(negedge clk) begin
    logic [9:0] e;
    if (rst_n && vA && rdyA) begin
      e = (qA.size() > 0) ? qA.pop_front() : 'x;
      chk("A head", {22'd0, extA, brkA, codeA}, {22'd0, e});
    end
    if (rst_n && vB && rdyB) begin
      e = (qB.size() > 0) ? qB.pop_front() : 'x;
      chk("B head", {22'd0, extB, brkB, codeB}, {22'd0, e});
    end
    if (rst_n && perA) nPar++;
    if (rst_n && ferA) nFer++;
  end

  // mode 0: plain, 1: check RdValid latency after stop edge, 2: pop in push cycle
  task automatic frame(input logic [7:0] d, input bit badPar, input bit stopBit,
                       input int nData, input int mode);
    logic [10:0] bits;
    logic par;
    par  = (~^d) ^ badPar;
    bits = {stopBit, par, d, 1'b0};
    if (nData < 8 || !stopBit || badPar) begin
      mExt = 1'b0;
      mBrk = 1'b0;
    end else begin
      qB.push_back({2'b00, d});
      if (d == 8'hE0) mExt = 1'b1;
      else if (d == 8'hF0) mBrk = 1'b1;
      else begin
        if (mode == 2 || qA.size() < DEPTH) qA.push_back({mExt, mBrk, d});
        mExt = 1'b0;
        mBrk = 1'b0;
      end
    end
    for (int i = 0; i < ((nData >= 8) ? 11 : 1 + nData); i++) begin
      @(posedge clk); #1 kd = bits[i];
      repeat (H) @(posedge clk);
      #1 kc = 1'b0;
      if (i == 10 && mode == 1) begin
        repeat (SYNC + 1) @(posedge clk);
        #1 chk("latency pre", {31'd0, vA}, 32'd0);
        @(posedge clk);
        #1 chk("latency", {31'd0, vA}, 32'd1);
      end else if (i == 10 && mode == 2) begin
        repeat (SYNC + 1) @(posedge clk);
        #1 rdyA = 1'b1;
        @(posedge clk);
        #1 rdyA = 1'b0;
      end else begin
        repeat (SYNC + 2) @(posedge clk);
      end
      repeat (H - SYNC - 2) @(posedge clk);
      #1 kc = 1'b1;
    end
    @(posedge clk); #1 kd = 1'b1;
  endtask

  task automatic popAll();
    @(posedge clk); #1 rdyA = 1'b1;
    repeat (DEPTH + 4) @(posedge clk);
    #1 rdyA = 1'b0;
    chk("drain count", {28'd0, cntA}, 32'd0);
    chk("drain queue", qA.size(), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; kc = 1'b1; kd = 1'b1; rdyA = 1'b0; clrErr = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("reset A", {17'd0, vA, codeA, extA, brkA, cntA, busyA, perA, ferA, ovA}, 32'd0);
    chk("reset B", {17'd0, vB, codeB, extB, brkB, cntB, busyB, perB, ferB, ovB}, 32'd0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);

    // Single good frame with latency check
    p0 = nPar; f0 = nFer;
    frame(8'h1C, 1'b0, 1'b1, 8, 1);
    chk("1C code", {24'd0, codeA}, 32'h1C);
    chk("1C flags", {30'd0, extA, brkA}, 32'd0);
    chk("1C count", {28'd0, cntA}, 32'd1);
    chk("1C no errs", nPar - p0 + nFer - f0, 32'd0);
    popAll();

    // E0 F0 75 folds into one flagged entry; raw instance sees three bytes
    frame(8'hE0, 1'b0, 1'b1, 8, 0);
    frame(8'hF0, 1'b0, 1'b1, 8, 0);
    frame(8'h75, 1'b0, 1'b1, 8, 0);
    chk("prefix count", {28'd0, cntA}, 32'd1);
    chk("prefix flags", {30'd0, extA, brkA}, 32'd3);
    chk("raw drained", qB.size(), 32'd0);
    popAll();

    // Parity error, then stop-bit error taking priority over bad parity
    p0 = nPar; f0 = nFer;
    frame(8'h1C, 1'b1, 1'b1, 8, 0);
    chk("parity pulse", nPar - p0, 32'd1);
    chk("parity no ferr", nFer - f0, 32'd0);
    chk("parity count", {28'd0, cntA}, 32'd0);
    p0 = nPar; f0 = nFer;
    frame(8'h1C, 1'b1, 1'b0, 8, 0);
    chk("stop pulse", nFer - f0, 32'd1);
    chk("stop no perr", nPar - p0, 32'd0);

    // A pending break prefix is discarded by an error frame
    frame(8'hF0, 1'b0, 1'b1, 8, 0);
    frame(8'h55, 1'b1, 1'b1, 8, 0);
    frame(8'h12, 1'b0, 1'b1, 8, 0);
    chk("err clears prefix", {30'd0, extA, brkA}, 32'd0);
    popAll();

    // Stalled frame times out
    frame(8'h00, 1'b0, 1'b1, 4, 0);
    chk("stall busy", {31'd0, busyA}, 32'd1);
    f0 = nFer;
    repeat (TO + 20) @(posedge clk);
    #1 chk("timeout pulse", nFer - f0, 32'd1);
    chk("timeout idle", {31'd0, busyA}, 32'd0);
    frame(8'h2A, 1'b0, 1'b1, 8, 0);
    chk("after timeout", {24'd0, codeA}, 32'h2A);
    popAll();

    // Fill past capacity
    for (int i = 0; i < 9; i++) frame(8'h10 + 8'(i), 1'b0, 1'b1, 8, 0);
    chk("full count", {28'd0, cntA}, 32'd8);
    chk("overflow set", {31'd0, ovA}, 32'd1);
    chk("full head", {24'd0, codeA}, 32'h10);
    @(posedge clk); #1 clrErr = 1'b1;
    @(posedge clk); #1 clrErr = 1'b0;
    chk("overflow clr", {31'd0, ovA}, 32'd0);

    // Push and pop together while full
    frame(8'h40, 1'b0, 1'b1, 8, 2);
    chk("full pushpop count", {28'd0, cntA}, 32'd8);
    chk("full pushpop no ovf", {31'd0, ovA}, 32'd0);
    chk("full pushpop head", {24'd0, codeA}, 32'h11);
    popAll();

    // Reset in the middle of a frame
    frame(8'h00, 1'b0, 1'b1, 4, 0);
    f0 = nFer;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("midreset A", {17'd0, vA, codeA, extA, brkA, cntA, busyA, perA, ferA, ovA}, 32'd0);
    qA.delete(); qB.delete();
    rst_n = 1'b1;
    frame(8'h33, 1'b0, 1'b1, 8, 0);
    chk("post reset code", {24'd0, codeA}, 32'h33);
    chk("post reset count", {28'd0, cntA}, 32'd1);
    chk("post reset no ferr", nFer - f0, 32'd0);
    popAll();
    chk("raw final", qB.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
